// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network front end.
// Used by the rate encoder and its per-channel LFSRs.
package snn_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ENCODE = 1'b1
  } enc_state_t;

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] SEED_STRIDE = 16'h9E37;

  // Per-channel seed: base XOR (channel * stride), kept to 16 bits.
  function automatic logic [15:0] lfsr_seed(input logic [15:0] base, input int unsigned ch);
    logic [31:0] prod;
    prod = ch * 32'(SEED_STRIDE);
    return base ^ prod[15:0];
  endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Sample-in / spike-out bundle between the pixel source and the rate encoder.
interface spike_rate_encoder_if #(
  parameter int NUM_CHANNELS = 1,
  parameter int PIXEL_WIDTH  = 8
);
  logic                                  pixel_valid;
  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0]   pixel_data;
  logic                                  pixel_ready;
  logic                                  abort;
  logic [NUM_CHANNELS-1:0]               spike_out;
  logic                                  busy;
  logic                                  window_done;

  modport master (
    output pixel_valid, pixel_data, abort,
    input  pixel_ready, spike_out, busy, window_done
  );

  modport slave (
    input  pixel_valid, pixel_data, abort,
    output pixel_ready, spike_out, busy, window_done
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1); seed loaded on reset, steps when en=1.
module lfsr16
  import snn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] r_value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= seed;
    end else if (en) begin
      r_value <= (r_value >> 1) ^ (r_value[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/spike_rate_encoder.sv
// Bernoulli rate encoder: latches one intensity vector, then emits WINDOW_LEN
// cycles of spikes where each channel fires when its LFSR low bits < intensity.
module spike_rate_encoder
  import snn_pkg::*;
#(
  parameter int          NUM_CHANNELS = 1,
  parameter int          PIXEL_WIDTH  = 8,
  parameter int          WINDOW_LEN   = 256,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic                  clk,
  input logic                  rst,
  spike_rate_encoder_if.slave  bus
);

  localparam int              CNT_W    = $clog2(WINDOW_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_LEN - 1);

  enc_state_t                          r_state;
  enc_state_t                          w_next_state;
  logic [CNT_W-1:0]                    r_count;
  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0] r_intensity;
  logic [NUM_CHANNELS-1:0]             r_spike;
  logic                                r_done;

  logic                                w_accept;
  logic                                w_finish;
  logic                                w_lfsr_en;
  logic [NUM_CHANNELS-1:0]             w_spike_calc;
  logic [NUM_CHANNELS-1:0]             w_lfsr_unused;
  logic [15:0]                         w_lfsr [NUM_CHANNELS];

  assign w_accept  = (r_state == IDLE) && bus.pixel_valid;
  assign w_finish  = (r_state == ENCODE) && (bus.abort || (r_count == LAST_CNT));
  // The first spike is computed on the acceptance edge, so the LFSR steps once per spike shown.
  assign w_lfsr_en = w_accept || ((r_state == ENCODE) && !w_finish);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (w_lfsr_en),
      .seed  (lfsr_seed(LFSR_SEED, c)),
      .value (w_lfsr[c])
    );

    assign w_spike_calc[c] = w_lfsr[c][PIXEL_WIDTH-1:0] <
                             (w_accept ? bus.pixel_data[c*PIXEL_WIDTH +: PIXEL_WIDTH]
                                       : r_intensity[c*PIXEL_WIDTH +: PIXEL_WIDTH]);
    assign w_lfsr_unused[c] = ^w_lfsr[c];
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ENCODE;
      ENCODE:  if (w_finish) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_intensity <= '0;
      r_spike     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_finish;

      if (w_accept) begin
        r_intensity <= bus.pixel_data;
        r_count     <= '0;
      end else if (r_state == ENCODE) begin
        r_count <= r_count + 1'b1;
      end

      if (w_finish) begin
        r_spike <= '0;
      end else if (w_accept || (r_state == ENCODE)) begin
        r_spike <= w_spike_calc;
      end
    end
  end

  assign bus.pixel_ready = (r_state == IDLE);
  assign bus.busy        = (r_state == ENCODE);
  assign bus.spike_out   = r_spike;
  assign bus.window_done = r_done;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed + randomized bench for spike_rate_encoder against a precomputed LFSR sequence model.
module tb_spike_rate_encoder;

  localparam int NC    = 1;
  localparam int PW    = 8;
  localparam int WL    = 256;
  localparam int SEQ_N = 8192;

  logic clk;
  logic rst;

  spike_rate_encoder_if #(.NUM_CHANNELS(NC), .PIXEL_WIDTH(PW)) bus ();

  spike_rate_encoder #(
    .NUM_CHANNELS (NC),
    .PIXEL_WIDTH  (PW),
    .WINDOW_LEN   (WL),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] lfsr_seq [SEQ_N];
  int          m_pos;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.pixel_ready), 32'd1);
    chk({tag, "_busy"},  32'(bus.busy),        32'd0);
    chk({tag, "_spike"}, 32'(bus.spike_out),   32'd0);
    chk({tag, "_done"},  32'(bus.window_done), 32'd0);
  endtask

  // Expected spike total for n draws starting at sequence position start.
  function automatic int model_count(input int start, input logic [7:0] inten, input int n);
    int total = 0;
    for (int i = 0; i < n; i++) total += (lfsr_seq[start + i][7:0] < inten) ? 1 : 0;
    return total;
  endfunction

  task automatic accept(input logic [7:0] d);
    int waited = 0;
    bus.pixel_valid = 1'b1;
    bus.pixel_data  = d;
    while (bus.pixel_ready !== 1'b1 && waited < 2 * WL) begin
      tick();
      waited++;
    end
    chk("accept_ready", 32'(bus.pixel_ready), 32'd1);
    tick();
    bus.pixel_valid = 1'b0;
  endtask

  // Starts in the first spike cycle; ends in the window_done cycle.
  task automatic encode(input logic [7:0] inten, input int abort_at, input int hold_at,
                        input logic [7:0] hold_data, output int spikes);
    logic e;
    spikes = 0;
    chk("start_done_low", 32'(bus.window_done), 32'd0);
    for (int k = 0; k < WL; k++) begin
      e = lfsr_seq[m_pos][7:0] < inten;
      m_pos++;
      chk($sformatf("spike_i%0d_k%0d", inten, k), 32'(bus.spike_out), 32'(e));
      chk("enc_busy",  32'(bus.busy),        32'd1);
      chk("enc_ready", 32'(bus.pixel_ready), 32'd0);
      if (k > 0) chk("enc_done_low", 32'(bus.window_done), 32'd0);
      spikes += int'(bus.spike_out);
      if (k == hold_at) begin
        bus.pixel_valid = 1'b1;
        bus.pixel_data  = hold_data;
      end
      if (k == abort_at) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        break;
      end
      tick();
    end
    chk("end_spike", 32'(bus.spike_out),   32'd0);
    chk("end_busy",  32'(bus.busy),        32'd0);
    chk("end_ready", 32'(bus.pixel_ready), 32'd1);
    chk("end_done",  32'(bus.window_done), 32'd1);
  endtask

  initial begin
    logic [15:0] v;
    logic [7:0]  x, y;
    int          cnt, exp_cnt, ab;

    bus.pixel_valid = 1'b0;
    bus.pixel_data  = '0;
    bus.abort       = 1'b0;
    rst             = 1'b1;

    v = 16'hACE1;
    for (int i = 0; i < SEQ_N; i++) begin
      lfsr_seq[i] = v;
      v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    end

    repeat (3) tick();
    chk_idle_outputs("reset");
    rst   = 1'b0;
    m_pos = 0;
    tick();
    chk_idle_outputs("post_reset");

    // Seed low byte 225: intensity 226 fires on the first cycle, 225 does not.
    accept(8'd226);
    chk("first_spike_226", 32'(bus.spike_out), 32'd1);
    encode(8'd226, -1, -1, 8'd0, cnt);

    rst = 1'b1;
    #1;
    chk_idle_outputs("reset2");
    tick();
    rst   = 1'b0;
    m_pos = 0;
    accept(8'd225);
    chk("first_spike_225", 32'(bus.spike_out), 32'd0);
    encode(8'd225, -1, -1, 8'd0, cnt);

    accept(8'd0);
    encode(8'd0, -1, -1, 8'd0, cnt);
    chk("count_0", 32'(cnt), 32'd0);

    exp_cnt = model_count(m_pos, 8'd255, WL);
    accept(8'd255);
    encode(8'd255, -1, -1, 8'd0, cnt);
    chk("count_255", 32'(cnt), 32'(exp_cnt));

    exp_cnt = model_count(m_pos, 8'd128, WL);
    accept(8'd128);
    encode(8'd128, -1, -1, 8'd0, cnt);
    chk("count_128", 32'(cnt), 32'(exp_cnt));
    chk("count_128_in_96_160", 32'((cnt >= 96) && (cnt <= 160)), 32'd1);

    // New sample offered mid-window must wait for window_done.
    x = 8'($urandom_range(1, 254));
    y = x ^ 8'h5A;
    accept(x);
    encode(x, -1, 5, y, cnt);
    tick();
    bus.pixel_valid = 1'b0;
    chk("held_sample_accepted", 32'(bus.busy), 32'd1);
    encode(y, -1, -1, 8'd0, cnt);

    // Abort at counter 10; the next window continues the same LFSR stream.
    x       = 8'($urandom_range(1, 255));
    exp_cnt = model_count(m_pos, x, 11);
    accept(x);
    encode(x, 10, -1, 8'd0, cnt);
    chk("abort_count", 32'(cnt), 32'(exp_cnt));
    tick();
    chk_idle_outputs("after_abort");
    x = 8'($urandom_range(0, 255));
    accept(x);
    encode(x, -1, -1, 8'd0, cnt);

    // Asynchronous reset at counter 100.
    accept(8'($urandom_range(1, 255)));
    repeat (100) tick();
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    tick();
    chk("mid_reset_no_done", 32'(bus.window_done), 32'd0);
    rst   = 1'b0;
    m_pos = 0;
    accept(8'd226);
    chk("rerun_first_spike", 32'(bus.spike_out), 32'd1);
    encode(8'd226, -1, -1, 8'd0, cnt);

    for (int w = 0; w < 3; w++) begin
      x  = 8'($urandom_range(0, 255));
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, WL - 1)) : -1;
      exp_cnt = model_count(m_pos, x, (ab < 0) ? WL : ab + 1);
      accept(x);
      encode(x, ab, -1, 8'd0, cnt);
      chk($sformatf("rand_count_w%0d", w), 32'(cnt), 32'(exp_cnt));
    end

    tick();
    chk_idle_outputs("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
